// File: rtl/conv_maxpool.sv
// conv_maxpool: 2x2 stride-2 max pooling on the convolver's raster-order
// result stream, using a half-row line buffer. Pooled pixels are written
// with a linear address to the output memory.
//
// Optional feature macro: CONV_MAXPOOL_RELU_EN
//   defined   -> input pixels are signed; negatives clamp to 0 before pooling
//   undefined -> pixels pass unmodified and compare unsigned
//
// Ports:
//   clk          clock
//   rst          asynchronous active-low reset
//   start_i      one-cycle start pulse; cols_i/rows_i latched on it
//   cols_i       input frame width in pixels
//   rows_i       input frame height in pixels
//   res_data_i   convolver result pixel
//   res_wr_i     result pixel valid (one pixel per asserted cycle)
//   pool_addr_o  pooled pixel linear address
//   pool_data_o  pooled pixel
//   pool_wr_o    pooled pixel write strobe
//   pool_en_o    output memory enable (asserted with pool_wr_o)
//   busy_o       high while a frame is running
//   done_o       one-cycle frame-complete pulse
//   err_o        sticky bad-configuration flag, cleared on next start
module conv_maxpool #(
  parameter int unsigned ADDR     = 16,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_COLS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [ADDR-1:0]  cols_i,
  input  logic [ADDR-1:0]  rows_i,
  input  logic [WIDTH-1:0] res_data_i,
  input  logic             res_wr_i,
  output logic [ADDR-1:0]  pool_addr_o,
  output logic [WIDTH-1:0] pool_data_o,
  output logic             pool_wr_o,
  output logic             pool_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int unsigned LB_DEPTH = (MAX_COLS / 2 > 0) ? MAX_COLS / 2 : 1;
  localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] f_max(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [ADDR-1:0]  r_cols, w_cols_nxt;
  logic [ADDR-1:0]  r_rows, w_rows_nxt;
  logic [ADDR-1:0]  r_col, w_col_nxt;
  logic [ADDR-1:0]  r_row, w_row_nxt;
  logic [ADDR-1:0]  r_out_cnt, w_out_cnt_nxt;
  logic [WIDTH-1:0] r_hold, w_hold_nxt;
  logic [ADDR-1:0]  r_pool_addr, w_pool_addr_nxt;
  logic [WIDTH-1:0] r_pool_data, w_pool_data_nxt;
  logic             r_pool_wr, w_pool_wr_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;

  logic [WIDTH-1:0] r_linebuf [LB_DEPTH];

  logic [WIDTH-1:0] w_pix;
  logic [LB_AW-1:0] w_lb_idx;
  logic [WIDTH-1:0] w_lb_rd;
  logic [WIDTH-1:0] w_max_hp;
  logic [WIDTH-1:0] w_max_all;
  logic             w_lb_we;
  logic             w_last_col;
  logic             w_last_row;
  logic             w_cfg_bad;

  // Input conditioning ahead of the pooling datapath
`ifdef CONV_MAXPOOL_RELU_EN
  assign w_pix = res_data_i[WIDTH-1] ? '0 : res_data_i;
`else
  assign w_pix = res_data_i;
`endif

  // Pooling datapath: the line buffer holds the top-row pair max per window
  assign w_lb_idx   = LB_AW'(r_col >> 1);
  assign w_lb_rd    = r_linebuf[w_lb_idx];
  assign w_max_hp   = f_max(r_hold, w_pix);
  assign w_max_all  = f_max(w_lb_rd, w_max_hp);
  assign w_last_col = (r_col == r_cols - 1'b1);
  assign w_last_row = (r_row == r_rows - 1'b1);
  assign w_cfg_bad  = (cols_i < ADDR'(2)) || (rows_i < ADDR'(2)) ||
                      (cols_i > ADDR'(MAX_COLS));

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_cols_nxt      = r_cols;
    w_rows_nxt      = r_rows;
    w_col_nxt       = r_col;
    w_row_nxt       = r_row;
    w_out_cnt_nxt   = r_out_cnt;
    w_hold_nxt      = r_hold;
    w_pool_addr_nxt = r_pool_addr;
    w_pool_data_nxt = r_pool_data;
    w_pool_wr_nxt   = 1'b0;
    w_err_nxt       = r_err;
    w_lb_we         = 1'b0;
    w_busy_nxt      = 1'b0;
    w_done_nxt      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_cols_nxt    = cols_i;
          w_rows_nxt    = rows_i;
          w_col_nxt     = '0;
          w_row_nxt     = '0;
          w_out_cnt_nxt = '0;
          if (w_cfg_bad) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_err_nxt   = 1'b0;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (res_wr_i) begin
          if (!r_col[0]) begin
            w_hold_nxt = w_pix;
          end else if (!r_row[0]) begin
            w_lb_we = 1'b1;
          end else begin
            w_pool_wr_nxt   = 1'b1;
            w_pool_data_nxt = w_max_all;
            w_pool_addr_nxt = r_out_cnt;
            w_out_cnt_nxt   = r_out_cnt + 1'b1;
          end
          // Raster position advance; the final pixel ends the frame
          if (w_last_col) begin
            w_col_nxt = '0;
            w_row_nxt = r_row + 1'b1;
            if (w_last_row) begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_col_nxt = r_col + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_RUN);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cols      <= '0;
      r_rows      <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_out_cnt   <= '0;
      r_hold      <= '0;
      r_pool_addr <= '0;
      r_pool_data <= '0;
      r_pool_wr   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cols      <= w_cols_nxt;
      r_rows      <= w_rows_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_out_cnt   <= w_out_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_pool_addr <= w_pool_addr_nxt;
      r_pool_data <= w_pool_data_nxt;
      r_pool_wr   <= w_pool_wr_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Line buffer storage; contents need no reset
  always_ff @(posedge clk) begin
    if (w_lb_we) begin
      r_linebuf[w_lb_idx] <= w_max_hp;
    end
  end

  assign pool_addr_o = r_pool_addr;
  assign pool_data_o = r_pool_data;
  assign pool_wr_o   = r_pool_wr;
  assign pool_en_o   = r_pool_wr;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_conv_maxpool.sv
// Self-checking bench for conv_maxpool: randomized frames and the listed
// directed cases, compared against a window-level pooling model.
module tb_conv_maxpool;

  localparam int unsigned ADDR     = 16;
  localparam int unsigned WIDTH    = 8;
  localparam int unsigned MAX_COLS = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start_i = 1'b0;
  logic [ADDR-1:0]  cols_i = '0;
  logic [ADDR-1:0]  rows_i = '0;
  logic [WIDTH-1:0] res_data_i = '0;
  logic             res_wr_i = 1'b0;
  logic [ADDR-1:0]  pool_addr_o;
  logic [WIDTH-1:0] pool_data_o;
  logic             pool_wr_o;
  logic             pool_en_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  conv_maxpool #(.ADDR(ADDR), .WIDTH(WIDTH), .MAX_COLS(MAX_COLS)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cols_i(cols_i), .rows_i(rows_i),
    .res_data_i(res_data_i), .res_wr_i(res_wr_i), .pool_addr_o(pool_addr_o),
    .pool_data_o(pool_data_o), .pool_wr_o(pool_wr_o), .pool_en_o(pool_en_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor, sampled on the falling edge
  int unsigned      wr_cyc[$];
  logic [ADDR-1:0]  wr_addr[$];
  logic [WIDTH-1:0] wr_data[$];
  int unsigned      done_cyc[$];
  int               en_bad = 0;

  always @(negedge clk) begin
    if (pool_wr_o) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(pool_addr_o);
      wr_data.push_back(pool_data_o);
    end
    if (done_o) done_cyc.push_back(cyc);
    if (pool_en_o !== pool_wr_o) en_bad++;
  end

  task automatic clear_mon();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); done_cyc.delete();
    en_bad = 0;
  endtask

  logic [WIDTH-1:0] frame_pix[$];

  function automatic logic [WIDTH-1:0] relu(input logic [WIDTH-1:0] p);
`ifdef CONV_MAXPOOL_RELU_EN
    return p[WIDTH-1] ? '0 : p;
`else
    return p;
`endif
  endfunction

  function automatic void fill_seq(input int n);
    frame_pix.delete();
    for (int i = 0; i < n; i++) frame_pix.push_back(WIDTH'(i));
  endfunction

  function automatic void fill_rand(input int n);
    frame_pix.delete();
    for (int i = 0; i < n; i++) frame_pix.push_back(WIDTH'($urandom));
  endfunction

  // Streams frame_pix as a cols x rows frame and checks every pooled write
  task automatic run_frame(input int cols, input int rows, input int gap_pct,
                           input bit mid_start, input string tag);
    int          n;
    int unsigned acc[];
    int          exp_cnt;
    int          k;
    int          idx;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] v;
    n   = cols * rows;
    acc = new[n];
    clear_mon();
    @(negedge clk);
    start_i = 1'b1; cols_i = ADDR'(cols); rows_i = ADDR'(rows);
    @(negedge clk);
    start_i = 1'b0;
    check({tag, "_busy_start"}, {31'd0, busy_o}, 32'd1);
    check({tag, "_err_start"}, {31'd0, err_o}, 32'd0);
    for (int i = 0; i < n; i++) begin
      if (mid_start && i == n / 2) begin
        start_i = 1'b1; cols_i = '0; rows_i = '0;
        @(negedge clk);
        start_i = 1'b0;
      end
      if (int'($urandom_range(99)) < gap_pct) @(negedge clk);
      res_wr_i = 1'b1; res_data_i = frame_pix[i];
      @(negedge clk);
      acc[i] = cyc;
      res_wr_i = 1'b0; res_data_i = WIDTH'($urandom);
    end
    repeat (4) @(negedge clk);
    check({tag, "_busy_end"}, {31'd0, busy_o}, 32'd0);
    exp_cnt = (cols / 2) * (rows / 2);
    check({tag, "_wr_count"}, wr_cyc.size(), exp_cnt);
    k = 0;
    for (int wr = 0; wr < rows / 2; wr++) begin
      for (int wc = 0; wc < cols / 2; wc++) begin
        m = '0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++) begin
            v = relu(frame_pix[(2 * wr + dr) * cols + 2 * wc + dc]);
            if (v > m) m = v;
          end
        idx = (2 * wr + 1) * cols + 2 * wc + 1;
        if (k < wr_cyc.size()) begin
          check({tag, "_addr"}, wr_addr[k], k);
          check({tag, "_data"}, wr_data[k], m);
          check({tag, "_lat"}, wr_cyc[k], acc[idx]);
        end
        k++;
      end
    end
    check({tag, "_done_count"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) check({tag, "_done_cyc"}, done_cyc[0], acc[n - 1]);
    check({tag, "_en"}, en_bad, 0);
    check({tag, "_err_end"}, {31'd0, err_o}, 32'd0);
  endtask

  // Bad configuration: immediate done with sticky error, no writes
  task automatic run_bad(input int cols, input int rows, input string tag);
    clear_mon();
    @(negedge clk);
    start_i = 1'b1; cols_i = ADDR'(cols); rows_i = ADDR'(rows);
    @(negedge clk);
    start_i = 1'b0;
    check({tag, "_done"}, {31'd0, done_o}, 32'd1);
    check({tag, "_err"}, {31'd0, err_o}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    repeat (3) begin
      res_wr_i = 1'b1; res_data_i = WIDTH'($urandom);
      @(negedge clk);
    end
    res_wr_i = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_wr_count"}, wr_cyc.size(), 0);
    check({tag, "_done_count"}, done_cyc.size(), 1);
    check({tag, "_err_sticky"}, {31'd0, err_o}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outs", {3'd0, pool_addr_o, pool_data_o, pool_wr_o, pool_en_o,
                         busy_o, done_o, err_o}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    fill_seq(16); run_frame(4, 4, 0, 1'b0, "f4x4");
    fill_seq(15); run_frame(5, 3, 0, 1'b0, "f5x3");
    fill_seq(16); run_frame(4, 4, 40, 1'b0, "f4x4_gap");

    run_bad(0, 4, "bad_c0");
    fill_seq(16); run_frame(4, 4, 0, 1'b0, "after_bad");
    run_bad(1, 4, "bad_c1");
    run_bad(4, 1, "bad_r1");
    run_bad(MAX_COLS + 1, 2, "bad_wide");

    // Reset in the middle of a frame
    clear_mon();
    @(negedge clk);
    start_i = 1'b1; cols_i = 16'd4; rows_i = 16'd4;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      res_wr_i = 1'b1; res_data_i = WIDTH'(i);
      @(negedge clk);
    end
    res_wr_i = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_outs", {3'd0, pool_addr_o, pool_data_o, pool_wr_o, pool_en_o,
                          busy_o, done_o, err_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_cyc.size(), 0);
    check("midrst_idle", {31'd0, busy_o}, 32'd0);
    fill_seq(16); run_frame(4, 4, 0, 1'b0, "after_rst");

    // Sign-boundary frame, with a stray start during the run
    frame_pix.delete();
    frame_pix.push_back(8'h80); frame_pix.push_back(8'h01);
    frame_pix.push_back(8'h02); frame_pix.push_back(8'h03);
    run_frame(2, 2, 0, 1'b1, "f2x2_sign");

    fill_rand(MAX_COLS * 2); run_frame(MAX_COLS, 2, 20, 1'b0, "full_width");
    fill_rand(MAX_COLS * 3); run_frame(MAX_COLS - 1, 3, 0, 1'b0, "wide_odd");

    for (int t = 0; t < 10; t++) begin
      int c;
      int r;
      c = int'($urandom_range(2, 12));
      r = int'($urandom_range(2, 9));
      fill_rand(c * r);
      run_frame(c, r, 30, (t % 3) == 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
